// File: rtl/i2s_transmitter.sv
`timescale 1ns/1ps
// i2s_transmitter: serialises a stereo BITS-wide sample pair into a 64-slot I2S frame, MSB first.
// Latency: all outputs are registered and take their new slot's value on the clk_i2s_pulse edge itself.
// Backpressure: none; samples are captured once per frame and DAC_* changes between captures are ignored.
//
// Ports:
//   clk_in, rst            - system clock, synchronous active-high reset
//   clk_i2s, clk_i2s_pulse - 50/50 bit clock and its one-cycle start-of-period strobe (from fp_div)
//   sample_in              - frame resync: forces the next slot to 0 on a strobe edge
//   DAC_Left, DAC_Right    - stereo sample inputs, captured when the slot counter wraps to 0
//   sample_pulse           - one-cycle pulse in the cycle after a capture
//   I2S_BCLK/WCLK/DATA     - serial outputs to the DAC
//
// Build option: define I2S_LEFT_JUSTIFIED_EN for left-justified framing (WCLK high for slots 0..31,
// edges coincide with each channel's MSB). Default is standard I2S (WCLK leads the MSB by one bit).
module i2s_transmitter #(
    parameter int BITS     = 16,   // 1..32
    parameter int INV_BCLK = 0
) (
    input  logic            clk_in,
    input  logic            rst,
    input  logic            clk_i2s,
    input  logic            clk_i2s_pulse,
    input  logic            sample_in,
    input  logic [BITS-1:0] DAC_Left,
    input  logic [BITS-1:0] DAC_Right,
    output logic            sample_pulse,
    output logic            I2S_BCLK,
    output logic            I2S_WCLK,
    output logic            I2S_DATA
);

    localparam logic       INV   = (INV_BCLK != 0);
    localparam logic [6:0] L_END = 7'(BITS);        // first slot past the left word
    localparam logic [6:0] R_END = 7'(32 + BITS);   // first slot past the right word

    logic [5:0]      pos_q,   pos_d;
    logic [6:0]      pos7_d;
    logic [BITS-1:0] lsr_q,   lsr_d;
    logic [BITS-1:0] rsr_q,   rsr_d;
    logic            data_q,  data_d;
    logic            wclk_q,  wclk_d;
    logic            pulse_q, pulse_d;
    logic            bclk_q;

    always_comb begin
        pos_d   = pos_q;
        pos7_d  = {1'b0, pos_q};
        lsr_d   = lsr_q;
        rsr_d   = rsr_q;
        data_d  = data_q;
        wclk_d  = wclk_q;
        pulse_d = 1'b0;

        if (clk_i2s_pulse) begin
            // Resync wins over the normal advance; a resync at slot 63 lands on the
            // same slot 0 as a natural wrap, so it produces no extra capture.
            pos_d  = sample_in ? 6'd0 : pos_q + 6'd1;
            pos7_d = {1'b0, pos_d};

            if (pos_d == 6'd0) begin
                // Capture edge: the left MSB goes straight out from the input so the
                // new frame starts on this same edge; the register keeps the remainder.
                data_d  = DAC_Left[BITS-1];
                lsr_d   = DAC_Left << 1;
                rsr_d   = DAC_Right;
                pulse_d = 1'b1;
            end else if (pos7_d < L_END) begin
                data_d = lsr_q[BITS-1];
                lsr_d  = lsr_q << 1;
            end else if (pos7_d >= 7'd32 && pos7_d < R_END) begin
                data_d = rsr_q[BITS-1];
                rsr_d  = rsr_q << 1;
            end else begin
                data_d = 1'b0;
            end

`ifdef I2S_LEFT_JUSTIFIED_EN
            wclk_d = ~pos_d[5];
`else
            // One-bit lead: right channel is announced in slot 31, left again in slot 63.
            wclk_d = (pos_d >= 6'd31) && (pos_d != 6'd63);
`endif
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            pos_q   <= 6'd63;
            lsr_q   <= '0;
            rsr_q   <= '0;
            data_q  <= 1'b0;
            wclk_q  <= 1'b0;
            pulse_q <= 1'b0;
            bclk_q  <= INV;
        end else begin
            pos_q   <= pos_d;
            lsr_q   <= lsr_d;
            rsr_q   <= rsr_d;
            data_q  <= data_d;
            wclk_q  <= wclk_d;
            pulse_q <= pulse_d;
            // Non-inverted BCLK falls on the strobe edge where DATA/WCLK change,
            // so the DAC samples on the rising edge mid-bit.
            bclk_q  <= clk_i2s ^ ~INV;
        end
    end

    assign sample_pulse = pulse_q;
    assign I2S_BCLK     = bclk_q;
    assign I2S_WCLK     = wclk_q;
    assign I2S_DATA     = data_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
`timescale 1ns/1ps
module tb_i2s_transmitter;

    logic clk_in = 1'b0;
    logic rst = 1'b0;
    logic clk_i2s = 1'b0;
    logic clk_i2s_pulse = 1'b0;
    logic sample_in = 1'b0;
    logic [15:0] l16 = '0, r16 = '0;
    logic [23:0] l24 = '0, r24 = '0;
    logic sp16, bclk16, wclk16, data16;
    logic sp24, bclk24, wclk24, data24;

    always #5 clk_in = ~clk_in;

    i2s_transmitter #(.BITS(16), .INV_BCLK(0)) u_dut16 (
        .clk_in(clk_in), .rst(rst), .clk_i2s(clk_i2s), .clk_i2s_pulse(clk_i2s_pulse),
        .sample_in(sample_in), .DAC_Left(l16), .DAC_Right(r16),
        .sample_pulse(sp16), .I2S_BCLK(bclk16), .I2S_WCLK(wclk16), .I2S_DATA(data16));

    i2s_transmitter #(.BITS(24), .INV_BCLK(1)) u_dut24 (
        .clk_in(clk_in), .rst(rst), .clk_i2s(clk_i2s), .clk_i2s_pulse(clk_i2s_pulse),
        .sample_in(sample_in), .DAC_Left(l24), .DAC_Right(r24),
        .sample_pulse(sp24), .I2S_BCLK(bclk24), .I2S_WCLK(wclk24), .I2S_DATA(data24));

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: slot number, captured words per instance, capture flag.
    int          mpos = 63;
    logic [31:0] mL [2];
    logic [31:0] mR [2];
    bit          mcap = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (slot %0d, t=%0t)", tag, got, exp, mpos, $time);
        end
    endtask

    function automatic logic exp_data(input int k);
        int bits;
        bits = (k == 0) ? 16 : 24;
        if (mpos < bits)
            return mL[k][bits-1-mpos];
        if (mpos >= 32 && mpos < 32 + bits)
            return mR[k][bits-1-(mpos-32)];
        return 1'b0;
    endfunction

    function automatic logic exp_wclk();
`ifdef I2S_LEFT_JUSTIFIED_EN
        return (mpos <= 31);
`else
        return (mpos >= 31 && mpos <= 62);
`endif
    endfunction

    task automatic check_outputs();
        chk("data16",  data16, exp_data(0));
        chk("data24",  data24, exp_data(1));
        chk("wclk16",  wclk16, exp_wclk());
        chk("wclk24",  wclk24, exp_wclk());
        chk("pulse16", sp16,   mcap);
        chk("pulse24", sp24,   mcap);
    endtask

    // One bit-clock period: high half (strobe in its first cycle), then low half.
    task automatic strobe(input int half);
        clk_i2s       = 1'b1;
        clk_i2s_pulse = 1'b1;
        @(posedge clk_in);
        mpos = sample_in ? 0 : (mpos + 1) % 64;
        mcap = (mpos == 0);
        if (mcap) begin
            mL[0] = 32'(l16); mR[0] = 32'(r16);
            mL[1] = 32'(l24); mR[1] = 32'(r24);
        end
        @(negedge clk_in);
        clk_i2s_pulse = 1'b0;
        sample_in     = 1'b0;
        check_outputs();
        chk("bclk16_hi", bclk16, 1'b0);
        chk("bclk24_hi", bclk24, 1'b1);
        if (half > 1) begin
            repeat (half - 1) @(negedge clk_in);
            mcap = 1'b0;
            check_outputs();   // outputs hold between strobes, pulse is one cycle
        end
        clk_i2s = 1'b0;
        repeat (half) @(negedge clk_in);
        mcap = 1'b0;
        chk("bclk16_lo", bclk16, 1'b1);
        chk("bclk24_lo", bclk24, 1'b0);
    endtask

    task automatic do_reset(input bit with_strobe);
        rst = 1'b1;
        if (with_strobe) begin
            clk_i2s       = 1'b1;
            clk_i2s_pulse = 1'b1;
            sample_in     = 1'b1;
        end
        @(posedge clk_in);
        mpos = 63;
        mcap = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mL[k] = '0;
            mR[k] = '0;
        end
        @(negedge clk_in);
        rst           = 1'b0;
        clk_i2s       = 1'b0;
        clk_i2s_pulse = 1'b0;
        sample_in     = 1'b0;
        check_outputs();
        chk("rst_bclk16", bclk16, 1'b0);
        chk("rst_bclk24", bclk24, 1'b1);
    endtask

    initial begin
        int since;
        for (int k = 0; k < 2; k++) begin
            mL[k] = '0;
            mR[k] = '0;
        end
        @(negedge clk_in);
        do_reset(1'b0);

        // Alternating patterns, fastest strobe rate.
        l16 = 16'hAAAA; r16 = 16'h5555;
        l24 = 24'($urandom); r24 = 24'($urandom);
        repeat (64) strobe(1);

        // Left input changes mid-frame: current frame unaffected, next frame sends 8001.
        while (mpos != 40) strobe(1);
        l16 = 16'h8001;
        repeat (24 + 64) strobe(1);

        // Resync from slot 20.
        while (mpos != 20) strobe(1);
        sample_in = 1'b1;
        strobe(1);
        repeat (70) strobe(2);

        // Resync coinciding with the natural wrap.
        while (mpos != 63) strobe(1);
        sample_in = 1'b1;
        strobe(1);
        repeat (10) strobe(1);

        // Reset mid-frame, then the first strobe captures.
        while (mpos != 40) strobe(1);
        do_reset(1'b0);
        repeat (64) strobe(1);

        // Reset beats a simultaneous strobe with resync.
        repeat (5) strobe(1);
        do_reset(1'b1);
        repeat (10) strobe(1);

        // Randomised inputs, strobe spacing and sparse resyncs.
        since = 0;
        repeat (600) begin
            l16 = 16'($urandom); r16 = 16'($urandom);
            l24 = 24'($urandom); r24 = 24'($urandom);
            if (since >= 64 && $urandom_range(0, 40) == 0) begin
                sample_in = 1'b1;
                since = 0;
            end else begin
                since++;
            end
            strobe($urandom_range(1, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
